ni_packetizer: RTL

NI_PACKETIZER -- requirements
Module: ni_packetizer

---
 rtl/ni_packetizer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/ni_packetizer.sv
// ni_packetizer: frames a message into FF, dest, len, payload, 00 flits with 7D byte stuffing.
module ni_packetizer #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [7:0]       msg_dest,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             pay_valid,
  output logic             pay_ready,
  input  logic [7:0]       pay_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] HEAD = 3'd1;
  localparam logic [2:0] DEST = 3'd2;
  localparam logic [2:0] LEN  = 3'd3;
  localparam logic [2:0] PAY  = 3'd4;
  localparam logic [2:0] ESC  = 3'd5;
  localparam logic [2:0] TAIL = 3'd6;
  logic [2:0]       state_q, state_d, ret_q, ret_d, cur, nf;
  logic [7:0]       dest_q, dest_d, esc_q, esc_d, out_data_q, out_data_d, b;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d, cnt_nx;
  logic             out_valid_q, out_valid_d, adv, ld, spec;
  // State names the field loaded next; acceptance loads the head straight away.
  assign adv       = !out_valid_q || out_ready;
  assign cur       = (state_q == IDLE && msg_valid) ? HEAD : state_q;
  assign cnt_nx    = cnt_q + 1'b1;
  assign msg_ready = state_q == IDLE;
  assign pay_ready = state_q == PAY && adv;
  assign busy      = state_q != IDLE;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    dest_d      = dest_q;
    len_d       = len_q;
    esc_d       = esc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    ld          = 1'b0;
    b           = 8'h00;
    nf          = state_q;
    if (adv)
      case (cur)
        HEAD: begin
          out_data_d  = 8'hFF;
          out_valid_d = 1'b1;
          dest_d      = msg_dest;
          len_d       = msg_len;
          cnt_d       = '0;
          state_d     = DEST;
        end
        DEST: begin
          ld = 1'b1;
          b  = dest_q;
          nf = LEN;
        end
        LEN: begin
          ld = 1'b1;
          b  = 8'(len_q);
          nf = (len_q == '0) ? TAIL : PAY;
        end
        PAY: begin
          ld    = pay_valid;
          b     = pay_data;
          nf    = (cnt_nx == len_q) ? TAIL : PAY;
          cnt_d = pay_valid ? cnt_nx : cnt_q;
        end
        ESC: begin
          out_data_d  = esc_q;
          out_valid_d = 1'b1;
          state_d     = ret_q;
        end
        // 00 only ever appears unstuffed as the tail, so it marks the tail as loaded.
        TAIL: begin
          if (out_valid_q && out_data_q == 8'h00) state_d = IDLE;
          else begin
            out_data_d  = 8'h00;
            out_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    spec = b == 8'hFF || b == 8'h00 || b == 8'h7D;
    if (ld) begin
      out_valid_d = 1'b1;
      out_data_d  = spec ? 8'h7D : b;
      esc_d       = b ^ 8'h20;
      ret_d       = nf;
      state_d     = spec ? ESC : nf;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      dest_q      <= 8'h00;
      len_q       <= '0;
      esc_q       <= 8'h00;
      cnt_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      dest_q      <= dest_d;
      len_q       <= len_d;
      esc_q       <= esc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
